// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: assembles 16-bit instructions from two little-endian byte reads.
// Optional two-entry prefetch buffer when FETCH_PREFETCH_EN is defined.
module instr_fetch_unit #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] pc,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        align_err,
  output logic        fetch_err,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata
);

  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

  state_e            state_q;
  logic [15:0]       fetch_addr_q;
  logic [7:0]        lo_q;
  logic [15:0]       instr_buf_q;
  logic [15:0]       tag_q;
  logic              tag_valid_q;
  logic [CntW-1:0]   cnt_q;

  logic              hit0;
  logic              timeout_hit;
  logic              start_en;
  logic [15:0]       start_addr;

  assign hit0        = tag_valid_q && (tag_q == pc);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));
  assign align_err   = pc[0];
  assign stall       = ~instr_valid;

`ifdef FETCH_PREFETCH_EN
  logic [15:0] nbuf_q;
  logic [15:0] ntag_q;
  logic        nvalid_q;
  logic        pf_q;
  logic        hit1;
  logic        promote;
  logic        start_pf;

  assign hit1        = nvalid_q && (ntag_q == pc);
  assign instr_valid = (hit0 || hit1) && !pc[0];
  assign instr       = hit0 ? instr_buf_q : nbuf_q;
  assign promote     = hit1 && !hit0;

  always_comb begin
    start_en   = 1'b0;
    start_addr = pc;
    start_pf   = 1'b0;
    if (promote) begin
      // Promoted entry becomes primary; immediately look one instruction further ahead.
      start_en   = !fetch_err;
      start_addr = ntag_q + 16'd2;
      start_pf   = 1'b1;
    end else if (!instr_valid && !pc[0] && !fetch_err) begin
      start_en = 1'b1;
    end else if (hit0 && !nvalid_q && !fetch_err) begin
      start_en   = 1'b1;
      start_addr = tag_q + 16'd2;
      start_pf   = 1'b1;
    end
  end
`else
  assign instr_valid = hit0 && !pc[0];
  assign instr       = instr_buf_q;

  always_comb begin
    start_en   = !instr_valid && !pc[0] && !fetch_err;
    start_addr = pc;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= StIdle;
      fetch_addr_q <= 16'h0000;
      lo_q         <= 8'h00;
      instr_buf_q  <= 16'h0000;
      tag_q        <= 16'h0000;
      tag_valid_q  <= 1'b0;
      cnt_q        <= '0;
      mem_req      <= 1'b0;
      mem_addr     <= 16'h0000;
      fetch_err    <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      nbuf_q       <= 16'h0000;
      ntag_q       <= 16'h0000;
      nvalid_q     <= 1'b0;
      pf_q         <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          mem_req <= 1'b0;
`ifdef FETCH_PREFETCH_EN
          if (promote) begin
            instr_buf_q <= nbuf_q;
            tag_q       <= ntag_q;
            tag_valid_q <= 1'b1;
            nvalid_q    <= 1'b0;
          end
          if (start_en) pf_q <= start_pf;
`endif
          if (start_en) begin
            fetch_addr_q <= start_addr;
            mem_addr     <= start_addr;
            mem_req      <= 1'b1;
            cnt_q        <= '0;
            state_q      <= StLo;
          end
        end
        StLo: begin
          if (mem_ack) begin
            lo_q     <= mem_rdata;
            mem_addr <= fetch_addr_q + 16'd1;
            cnt_q    <= '0;
            state_q  <= StHi;
          end else if (timeout_hit) begin
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StHi: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            cnt_q   <= '0;
            state_q <= StIdle;
`ifdef FETCH_PREFETCH_EN
            if (pf_q) begin
              // Keep the prefetched word only while pc is still at X or X+2.
              if (pc == fetch_addr_q || pc == fetch_addr_q - 16'd2) begin
                nbuf_q   <= {mem_rdata, lo_q};
                ntag_q   <= fetch_addr_q;
                nvalid_q <= 1'b1;
              end
            end else begin
              instr_buf_q <= {mem_rdata, lo_q};
              tag_q       <= fetch_addr_q;
              tag_valid_q <= 1'b1;
              nvalid_q    <= 1'b0;
            end
`else
            instr_buf_q <= {mem_rdata, lo_q};
            tag_q       <= fetch_addr_q;
            tag_valid_q <= 1'b1;
`endif
          end else if (timeout_hit) begin
            fetch_err <= 1'b1;
            mem_req   <= 1'b0;
            cnt_q     <= '0;
            state_q   <= StIdle;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: byte memory model with configurable wait states
// and a queue of expected instructions popped whenever instr_valid is observed.
module tb_instr_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] pc;
  logic [15:0] instr;
  logic        instr_valid;
  logic        stall;
  logic        align_err;
  logic        fetch_err;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] exp_q[$];
  logic [15:0] ack_log[$];
  int          waits = 0;
  bit          ack_en = 1'b1;

  instr_fetch_unit #(.TIMEOUT(4)) dut (
    .clock       (clock),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .stall       (stall),
    .align_err   (align_err),
    .fetch_err   (fetch_err),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    if (a == 16'h0000) return 8'h34;
    if (a == 16'h0001) return 8'h12;
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [15:0] exp_instr(input logic [15:0] a);
    logic [15:0] a1;
    a1 = a + 16'd1;
    return {mem_byte(a1), mem_byte(a)};
  endfunction

  // Memory responder: decides the ack for the coming edge on each falling edge.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 8'h00;
    forever begin
      @(negedge clock);
      if (mem_req && ack_en) begin
        if (wcnt >= waits) begin
          mem_ack = 1'b1;
          mem_rdata = mem_byte(mem_addr);
          ack_log.push_back(mem_addr);
          wcnt = 0;
        end else begin
          mem_ack = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ack = 1'b0;
        wcnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset(input logic [15:0] addr);
    reset = 1'b1;
    pc = addr;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int cyc, output bit seen);
    cyc = 0;
    seen = 1'b0;
    while (cyc < max_cyc && !seen) begin
      @(negedge clock);
      cyc++;
      if (instr_valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset;
    logic [15:0] e;
    waits = 0;
    ack_en = 1'b1;
    reset = 1'b1;
    pc = 16'h0000;
    repeat (2) @(negedge clock);
    n_cmp++;
    if ({mem_req, mem_addr, stall, instr_valid, fetch_err, instr} !== {1'b0, 16'h0, 1'b1, 1'b0, 1'b0, 16'h0}) begin
      n_bad++;
      $display("FAIL reset_values: req=%b addr=%h stall=%b valid=%b ferr=%b instr=%h, want 0 0000 1 0 0 0000",
               mem_req, mem_addr, stall, instr_valid, fetch_err, instr);
    end
    reset = 1'b0;
    exp_q.push_back(16'h1234);
    @(negedge clock);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_first_req: req=%b addr=%h, want 1 0000", mem_req, mem_addr);
    end
    @(negedge clock);
    n_cmp++;
    if (instr_valid !== 1'b0 || mem_addr !== 16'h0001) begin
      n_bad++;
      $display("FAIL reset_hi_phase: valid=%b addr=%h, want 0 0001", instr_valid, mem_addr);
    end
    @(negedge clock);
    n_cmp++;
    if (instr_valid !== 1'b1 || stall !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_latency3: valid=%b stall=%b, want 1 0", instr_valid, stall);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (instr !== e) begin
      n_bad++;
      $display("FAIL reset_instr: got %h want %h", instr, e);
    end
  endtask

  task automatic test_wait_states;
    int  sc;
    bit  seen;
    logic [15:0] e;
    waits = 2;
    ack_log.delete();
    do_reset(16'h0010);
    exp_q.push_back(exp_instr(16'h0010));
    sc = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      if (instr_valid) seen = 1'b1;
      else if (stall && mem_req) sc++;
    end
    n_cmp++;
    if (!seen || sc != 6) begin
      n_bad++;
      $display("FAIL wait_stall_cycles: seen=%b stall cycles=%0d, want 1 6", seen, sc);
    end
    n_cmp++;
    if (ack_log.size() != 2 || ack_log[0] !== 16'h0010 || ack_log[1] !== 16'h0011) begin
      n_bad++;
      $display("FAIL wait_addr_order: got %0d acks first=%h, want 2 acks 0010 0011",
               ack_log.size(), (ack_log.size() > 0) ? ack_log[0] : 16'hxxxx);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (instr !== e) begin
      n_bad++;
      $display("FAIL wait_instr: got %h want %h", instr, e);
    end
    waits = 0;
  endtask

  task automatic test_pc_change;
    bit  seen;
    bit  early;
    logic [15:0] e;
    logic [15:0] want[4];
    want[0] = 16'h0020; want[1] = 16'h0021; want[2] = 16'h0040; want[3] = 16'h0041;
    waits = 1;
    ack_log.delete();
    do_reset(16'h0020);
    @(negedge clock);
    pc = 16'h0040;
    exp_q.push_back(exp_instr(16'h0040));
    seen = 1'b0;
    early = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge clock);
      if (instr_valid) seen = 1'b1;
      else if (!stall) early = 1'b1;
    end
    n_cmp++;
    if (!seen || early) begin
      n_bad++;
      $display("FAIL pcchg_valid: seen=%b stall_dropped=%b, want 1 0", seen, early);
    end
    n_cmp++;
    if (ack_log.size() != 4) begin
      n_bad++;
      $display("FAIL pcchg_ack_count: got %0d want 4", ack_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (ack_log[i] !== want[i]) begin
          n_bad++;
          $display("FAIL pcchg_addr%0d: got %h want %h", i, ack_log[i], want[i]);
        end
      end
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (instr !== e) begin
      n_bad++;
      $display("FAIL pcchg_instr: got %h want %h", instr, e);
    end
    pc = 16'h0020;
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL pcchg_old_tag: valid=%b want 0", instr_valid);
    end
    waits = 0;
  endtask

  task automatic test_align;
    int  bad;
    int  cyc;
    bit  seen;
    logic [15:0] e;
    do_reset(16'h0003);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (align_err !== 1'b1 || mem_req !== 1'b0 || stall !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL align_hold: %0d bad cycles, want 0", bad);
    end
    pc = 16'h0004;
    exp_q.push_back(exp_instr(16'h0004));
    wait_valid(20, cyc, seen);
    n_cmp++;
    if (!seen || cyc != 3 || align_err !== 1'b0) begin
      n_bad++;
      $display("FAIL align_recover: seen=%b cycles=%0d align_err=%b, want 1 3 0", seen, cyc, align_err);
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (instr !== e) begin
      n_bad++;
      $display("FAIL align_instr: got %h want %h", instr, e);
    end
  endtask

  task automatic test_timeout;
    int bad;
    do_reset(16'h0000);
    ack_en = 1'b0;
    @(negedge clock);
    repeat (3) @(negedge clock);
    n_cmp++;
    if (fetch_err !== 1'b0 || mem_req !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_early: ferr=%b req=%b, want 0 1", fetch_err, mem_req);
    end
    @(negedge clock);
    n_cmp++;
    if (fetch_err !== 1'b1 || mem_req !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_flag: ferr=%b req=%b, want 1 0", fetch_err, mem_req);
    end
    ack_en = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (mem_req !== 1'b0 || fetch_err !== 1'b1 || stall !== 1'b1) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++;
      $display("FAIL timeout_sticky: %0d bad cycles, want 0", bad);
    end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++;
    if (fetch_err !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_clear: ferr=%b want 0", fetch_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_wrap;
    int  cyc;
    bit  seen;
    logic [15:0] e;
    ack_log.delete();
    do_reset(16'hFFFE);
    exp_q.push_back(exp_instr(16'hFFFE));
    wait_valid(20, cyc, seen);
    n_cmp++;
    if (!seen || ack_log.size() < 2 || ack_log[0] !== 16'hFFFE || ack_log[1] !== 16'hFFFF) begin
      n_bad++;
      $display("FAIL wrap_addr: seen=%b acks=%0d, want 1 with FFFE FFFF", seen, ack_log.size());
    end
    e = exp_q.pop_front();
    n_cmp++;
    if (instr !== e) begin
      n_bad++;
      $display("FAIL wrap_instr: got %h want %h", instr, e);
    end
  endtask

  task automatic test_back_to_back;
    int  cyc;
    bit  seen;
    logic [15:0] e;
    do_reset(16'h0100);
    exp_q.push_back(exp_instr(16'h0100));
    wait_valid(20, cyc, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || instr !== e) begin
      n_bad++;
      $display("FAIL b2b_first: seen=%b instr=%h want %h", seen, instr, e);
    end
`ifdef FETCH_PREFETCH_EN
    @(negedge clock);
    for (int i = 0; i < 20 && mem_req; i++) @(negedge clock);
    pc = 16'h0102;
    exp_q.push_back(exp_instr(16'h0102));
    #1;
    e = exp_q.pop_front();
    n_cmp++;
    if (instr_valid !== 1'b1 || stall !== 1'b0 || instr !== e) begin
      n_bad++;
      $display("FAIL b2b_prefetch_hit: valid=%b stall=%b instr=%h, want 1 0 %h",
               instr_valid, stall, instr, e);
    end
    @(negedge clock);
    n_cmp++;
    if (mem_req !== 1'b1 || mem_addr !== 16'h0104 || instr_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_next_prefetch: req=%b addr=%h valid=%b, want 1 0104 1",
               mem_req, mem_addr, instr_valid);
    end
`else
    pc = 16'h0102;
    exp_q.push_back(exp_instr(16'h0102));
    #1;
    n_cmp++;
    if (instr_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_miss: valid=%b want 0", instr_valid);
    end
    wait_valid(20, cyc, seen);
    e = exp_q.pop_front();
    n_cmp++;
    if (!seen || cyc != 3 || instr !== e) begin
      n_bad++;
      $display("FAIL b2b_second: seen=%b cycles=%0d instr=%h, want 1 3 %h", seen, cyc, instr, e);
    end
`endif
  endtask

  initial begin
    reset = 1'b1;
    pc = 16'h0000;
    test_reset();
    test_wait_states();
    test_pc_change();
    test_align();
    test_timeout();
    test_wrap();
    test_back_to_back();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
